// File: rtl/alu_muldiv_seq.sv
// Sequencer that runs 8x8 unsigned multiply and 8/8 unsigned restoring divide
// on the shared 8-bit ALU, one shift-and-add/subtract step per CALC cycle.
module alu_muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_y,
    input  logic        alu_c,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        div0
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [7:0]  acc_q, acc_d;     // MUL: high product byte; DIV: remainder
    logic [7:0]  mq_q, mq_d;       // MUL: multiplier/low byte; DIV: quotient
    logic [7:0]  md_q, md_d;       // MUL: multiplicand; DIV: divisor
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic        div0_q, div0_d;
    logic [7:0]  div_s;

    // Partial remainder shifted left with the next dividend bit; its lost MSB is acc_q[7].
    assign div_s = {acc_q[6:0], mq_q[7]};

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        md_d     = md_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        div0_d   = div0_q;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_op   = OP_ADD;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    mode_d  = mode;
                    acc_d   = 8'h00;
                    mq_d    = mode ? op_a : op_b;
                    md_d    = mode ? op_b : op_a;
                    div0_d  = mode & (op_b == 8'h00);
                    cnt_d   = 3'd0;
                end
            end
            ST_CALC: begin
                if (!mode_q) begin
                    alu_a  = acc_q;
                    alu_b  = md_q;
                    alu_op = OP_ADD;
                    if (mq_q[0]) begin
                        {acc_d, mq_d} = {alu_c, alu_y, mq_q[7:1]};
                    end else begin
                        {acc_d, mq_d} = {1'b0, acc_q, mq_q[7:1]};
                    end
                end else begin
                    alu_a  = div_s;
                    alu_b  = md_q;
                    alu_op = OP_SUB;
                    // A set shifted-out MSB means the 9-bit remainder exceeds any divisor,
                    // and the 8-bit wrapped difference is then the exact remainder.
                    if (acc_q[7] || alu_c) begin
                        acc_d = alu_y;
                        mq_d  = {mq_q[6:0], 1'b1};
                    end else begin
                        acc_d = div_s;
                        mq_d  = {mq_q[6:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d  = ST_DONE;
                    result_d = {acc_d, mq_d};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            acc_q    <= 8'h00;
            mq_q     <= 8'h00;
            md_q     <= 8'h00;
            cnt_q    <= 3'd0;
            result_q <= 16'h0000;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            md_q     <= md_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            div0_q   <= div0_d;
        end
    end

    assign busy   = (state_q == ST_CALC);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign div0   = div0_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: behavioural ALU beside the DUT and a
// plain-arithmetic reference for products, quotients and remainders.
module tb_alu_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mode;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_y;
    logic        alu_c;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        div0;

    int checks;
    int failures;
    logic [15:0] prev_result;
    logic        prev_div0;

    alu_muldiv_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .op_a   (op_a),
        .op_b   (op_b),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .alu_y  (alu_y),
        .alu_c  (alu_c),
        .busy   (busy),
        .done   (done),
        .result (result),
        .div0   (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared ALU as seen from this block: ADD gives carry, SUB gives no-borrow.
    always_comb begin
        logic [8:0] sum;
        sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y = 8'h00;
        alu_c = 1'b0;
        case (alu_op)
            3'b000: begin
                alu_y = sum[7:0];
                alu_c = sum[8];
            end
            3'b001: begin
                alu_y = alu_a - alu_b;
                alu_c = (alu_a >= alu_b);
            end
            default: begin
                alu_y = 8'h00;
                alu_c = 1'b0;
            end
        endcase
    end

    function automatic logic [15:0] ref_result(input logic m, input logic [7:0] a, input logic [7:0] b);
        int unsigned ia;
        int unsigned ib;
        ia = a;
        ib = b;
        if (!m) return 16'(ia * ib);
        if (ib == 0) return {a, 8'hFF};
        return {8'(ia % ib), 8'(ia / ib)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge with the DUT in IDLE; ten cycles per op.
    task automatic run_op(input logic m, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] exp_res;
        logic        exp_div0;
        exp_res  = ref_result(m, a, b);
        exp_div0 = m && (b == 8'h00);
        start = 1'b1;
        mode  = m;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            check("calc_busy", {31'b0, busy}, 32'd1);
            check("calc_done", {31'b0, done}, 32'd0);
            if (cyc == 1) begin
                check("start_div0", {31'b0, div0}, {31'b0, exp_div0});
                check("result_hold", {16'b0, result}, {16'b0, prev_result});
                start = 1'b0;
                op_a  = 8'($urandom);
                op_b  = 8'($urandom);
                mode  = 1'($urandom);
            end
        end
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 32'd1);
        check("done_busy", {31'b0, busy}, 32'd0);
        check("done_result", {16'b0, result}, {16'b0, exp_res});
        check("done_div0", {31'b0, div0}, {31'b0, exp_div0});
        $display("op mode=%0d a=%02h b=%02h result=%04h exp=%04h div0=%0d", m, a, b, result, exp_res, div0);
        prev_result = exp_res;
        prev_div0   = exp_div0;
        @(negedge clk);
        check("idle_done", {31'b0, done}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_alu", {21'b0, alu_a, alu_op}, 32'd0);
        check("idle_result", {16'b0, result}, {16'b0, prev_result});
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        prev_result = 16'h0000;
        prev_div0   = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", {16'b0, result}, 32'd0);
        check("rst_div0", {31'b0, div0}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(1'b0, 8'h0D, 8'h0B);
        run_op(1'b0, 8'hFF, 8'hFF);
        run_op(1'b0, 8'h00, 8'h37);
        run_op(1'b1, 8'd200, 8'd7);
        run_op(1'b1, 8'hFF, 8'h01);
        run_op(1'b1, 8'h05, 8'h09);
        run_op(1'b1, 8'h80, 8'h00);
        run_op(1'b0, 8'h02, 8'h03);

        // start held high: accepted only in IDLE, a done every 10 cycles
        start = 1'b1;
        mode  = 1'b0;
        op_a  = 8'h0D;
        op_b  = 8'h0B;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check("hold_done", {31'b0, done}, {31'b0, (k % 10) == 9});
            check("hold_busy", {31'b0, busy}, {31'b0, ((k % 10) >= 1) && ((k % 10) <= 8)});
            if ((k % 10) == 9) begin
                check("hold_result", {16'b0, result}, 32'h008F);
                $display("held-start op at cycle %0d result=%04h", k, result);
            end
        end
        start = 1'b0;
        prev_result = 16'h008F;
        prev_div0   = 1'b0;
        @(negedge clk);

        // reset in the fourth CALC cycle of 200/7 aborts without a done
        start = 1'b1;
        mode  = 1'b1;
        op_a  = 8'd200;
        op_b  = 8'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", {16'b0, result}, 32'd0);
        check("abort_div0", {31'b0, div0}, 32'd0);
        $display("reset asserted mid-divide busy=%0d result=%04h", busy, result);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("post_abort_done", {31'b0, done}, 32'd0);
            check("post_abort_busy", {31'b0, busy}, 32'd0);
        end
        prev_result = 16'h0000;
        prev_div0   = 1'b0;
        run_op(1'b1, 8'd200, 8'd7);

        for (int n = 0; n < 20; n++) begin
            logic       rm;
            logic [7:0] ra;
            logic [7:0] rb;
            rm = 1'($urandom);
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run_op(rm, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
